// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU and its writeback stage.
//   - default data/address widths
//   - NZCV flag bit positions
//   - branch condition codes and their evaluation against NZCV
//   - ALU opcode encodings
package alu_pkg;

  localparam int DWIDTH_DEF = 16;
  localparam int AWIDTH_DEF = 4;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_SHL = 4'h5;
  localparam logic [3:0] OP_SHR = 4'h6;
  localparam logic [3:0] OP_MOV = 4'h7;

  function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    n  = f[FLAG_N];
    z  = f[FLAG_Z];
    cy = f[FLAG_C];
    v  = f[FLAG_V];
    case (c)
      COND_EQ: return z;
      COND_NE: return !z;
      COND_CS: return cy;
      COND_CC: return !cy;
      COND_MI: return n;
      COND_PL: return !n;
      COND_VS: return v;
      COND_VC: return !v;
      COND_HI: return cy & !z;
      COND_LS: return !cy | z;
      COND_GE: return n == v;
      COND_LT: return n != v;
      COND_GT: return !z & (n == v);
      COND_LE: return z | (n != v);
      COND_AL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: DEPTH-entry {addr,data} write buffer.
//   push/push_addr/push_data : enqueue at tail
//   pop                      : dequeue head
//   count                    : occupancy 0..DEPTH
//   ent_valid/addr/data      : all entries in age order, [0] = head (oldest)
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module wb_fifo #(
  parameter int DEPTH  = 2,
  parameter int AWIDTH = 4,
  parameter int DWIDTH = 16
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               push,
  input  logic [AWIDTH-1:0]                  push_addr,
  input  logic [DWIDTH-1:0]                  push_data,
  input  logic                               pop,
  output logic [$clog2(DEPTH):0]             count,
  output logic [DEPTH-1:0]                   ent_valid,
  output logic [DEPTH-1:0][AWIDTH-1:0]       ent_addr,
  output logic [DEPTH-1:0][DWIDTH-1:0]       ent_data
);
  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [AWIDTH-1:0] addr;
    logic [DWIDTH-1:0] data;
  } ent_t;

  ent_t          mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{addr: push_addr, data: push_data};
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: ;
      endcase
    end
  end

  // Rotate storage so the consumer sees entries oldest-first.
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [PW-1:0] idx;
    assign idx          = rd_ptr + PW'(i);
    assign ent_valid[i] = count > (PW+1)'(i);
    assign ent_addr[i]  = mem[idx].addr;
    assign ent_data[i]  = mem[idx].data;
  end

endmodule

// File: rtl/alu_writeback.sv
// alu_writeback: stage after the ALU.
//   in_*            : one ALU result per cycle, valid/ready handshake
//   flags           : committed NZCV, fed back to the ALU
//   rf_*            : head of the write buffer to the shared RF write port
//   fwd_*           : newest pending write matching fwd_addr
//   cond/cond_true  : branch condition on committed flags
//   busy            : write buffer non-empty
module alu_writeback
  import alu_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int AWIDTH = AWIDTH_DEF,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] in_rdata,
  input  logic [3:0]        in_flags,
  input  logic              in_wen,
  input  logic [AWIDTH-1:0] in_waddr,
  input  logic              in_fen,
  output logic [3:0]        flags,
  output logic              rf_we,
  output logic [AWIDTH-1:0] rf_waddr,
  output logic [DWIDTH-1:0] rf_wdata,
  input  logic              rf_ready,
  input  logic [AWIDTH-1:0] fwd_addr,
  output logic              fwd_hit,
  output logic [DWIDTH-1:0] fwd_data,
  input  logic [3:0]        cond,
  output logic              cond_true,
  output logic              busy
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]                  count;
  logic                           accept, push, pop;
  logic [DEPTH-1:0]               ent_valid;
  logic [DEPTH-1:0][AWIDTH-1:0]   ent_addr;
  logic [DEPTH-1:0][DWIDTH-1:0]   ent_data;

  // Ready depends only on registered occupancy, never on rf_ready.
  assign in_ready = reset_n & (count != CW'(DEPTH));
  assign accept   = in_valid & in_ready;
  assign push     = accept & in_wen;

  // Gated by reset_n so a reset mid-drain never leaks a write.
  assign rf_we    = reset_n & (count != '0);
  assign rf_waddr = ent_addr[0];
  assign rf_wdata = ent_data[0];
  assign pop      = rf_we & rf_ready;
  assign busy     = rf_we;

  wb_fifo #(.DEPTH(DEPTH), .AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_addr (in_waddr),
    .push_data (in_rdata),
    .pop       (pop),
    .count     (count),
    .ent_valid (ent_valid),
    .ent_addr  (ent_addr),
    .ent_data  (ent_data)
  );

  always_ff @(posedge clk) begin
    if (!reset_n)              flags <= '0;
    else if (accept && in_fen) flags <= in_flags;
  end

  // Entries are oldest-first, so the last match wins = youngest.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (reset_n && ent_valid[i] && ent_addr[i] == fwd_addr) begin
        fwd_hit  = 1'b1;
        fwd_data = ent_data[i];
      end
    end
  end

  assign cond_true = cond_eval(cond, flags);

endmodule

// File: tb/tb_alu_writeback.sv
module tb_alu_writeback;
  localparam int DEPTH = 2;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_rdata;
  logic [3:0]  in_flags;
  logic        in_wen;
  logic [3:0]  in_waddr;
  logic        in_fen;
  logic [3:0]  flags;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        rf_ready;
  logic [3:0]  fwd_addr;
  logic        fwd_hit;
  logic [15:0] fwd_data;
  logic [3:0]  cond;
  logic        cond_true;
  logic        busy;

  alu_writeback #(.DWIDTH(16), .AWIDTH(4), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_rdata(in_rdata), .in_flags(in_flags), .in_wen(in_wen), .in_waddr(in_waddr),
    .in_fen(in_fen), .flags(flags), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .rf_ready(rf_ready), .fwd_addr(fwd_addr), .fwd_hit(fwd_hit),
    .fwd_data(fwd_data), .cond(cond), .cond_true(cond_true), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pending writes as a queue of {addr,data}, oldest first.
  logic [19:0] q[$];
  logic [3:0]  mflags;
  bit          armed;
  int          vectors;
  int          errs;

  function automatic bit cond_ref(input logic [3:0] c, input logic [3:0] fl);
    bit n, z, cy, v;
    n = fl[3]; z = fl[2]; cy = fl[1]; v = fl[0];
    case (c)
      4'h0: return z;          4'h1: return !z;
      4'h2: return cy;         4'h3: return !cy;
      4'h4: return n;          4'h5: return !n;
      4'h6: return v;          4'h7: return !v;
      4'h8: return cy && !z;   4'h9: return !cy || z;
      4'hA: return n == v;     4'hB: return n != v;
      4'hC: return !z && n == v; 4'hD: return z || n != v;
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    bit          hit;
    logic [15:0] fd;
    bit          pend;
    hit = 0; fd = '0;
    if (reset_n) begin
      foreach (q[i]) if (q[i][19:16] == fwd_addr) begin hit = 1; fd = q[i][15:0]; end
    end
    pend = reset_n && q.size() != 0;
    chk("in_ready", 32'(in_ready), 32'(reset_n && q.size() != DEPTH));
    chk("rf_we", 32'(rf_we), 32'(pend));
    chk("busy", 32'(busy), 32'(pend));
    if (pend) begin
      chk("rf_waddr", 32'(rf_waddr), 32'(q[0][19:16]));
      chk("rf_wdata", 32'(rf_wdata), 32'(q[0][15:0]));
    end
    chk("flags", 32'(flags), 32'(mflags));
    chk("fwd_hit", 32'(fwd_hit), 32'(hit));
    chk("fwd_data", 32'(fwd_data), 32'(fd));
    chk("cond_true", 32'(cond_true), 32'(cond_ref(cond, mflags)));
  endtask

  // Drive one cycle, check combinational outputs before the edge, then
  // advance the model across the edge.
  task automatic step(input bit rn, input bit v, input logic [15:0] d, input logic [3:0] f,
                      input bit wen, input logic [3:0] wa, input bit fen, input bit rr,
                      input logic [3:0] fa, input logic [3:0] c);
    bit acc, pop;
    reset_n = rn; in_valid = v; in_rdata = d; in_flags = f; in_wen = wen;
    in_waddr = wa; in_fen = fen; rf_ready = rr; fwd_addr = fa; cond = c;
    #1;
    if (armed) check_outputs();
    vectors++;
    if (!rn) begin
      q.delete();
      mflags = 4'h0;
    end else begin
      acc = v && q.size() != DEPTH;
      pop = q.size() != 0 && rr;
      if (pop) void'(q.pop_front());
      if (acc && wen) q.push_back({wa, d});
      if (acc && fen) mflags = f;
    end
    @(posedge clk);
    #1;
    armed = 1;
  endtask

  task automatic idle(input bit rr, input logic [3:0] fa, input logic [3:0] c);
    step(1, 0, 16'h0, 4'h0, 0, 4'h0, 0, rr, fa, c);
  endtask

  task automatic wr(input logic [3:0] wa, input logic [15:0] d, input bit rr);
    step(1, 1, d, 4'hF, 1, wa, 0, rr, 4'h0, 4'h0);
  endtask

  initial begin
    armed = 0; vectors = 0; errs = 0; mflags = 4'h0;

    // Reset held 3 cycles with in_valid asserted.
    repeat (3) step(0, 1, 16'hAAAA, 4'hF, 1, 4'h2, 1, 1, 4'h2, 4'h0);
    chk("reset_flags", 32'(flags), 32'h0);
    idle(1, 4'h0, 4'h0);
    chk("post_reset_flags", 32'(flags), 32'h0);

    // Flag commit without a register write.
    step(1, 1, 16'h5555, 4'b0110, 0, 4'h1, 1, 1, 4'h0, 4'h0);
    chk("eq_true", 32'(cond_true), 32'h1);
    idle(1, 4'h0, 4'h2);
    idle(1, 4'h0, 4'hA);
    idle(1, 4'h0, 4'hB);
    chk("flags_0110", 32'(flags), 32'h6);

    // Back-pressure.
    wr(4'h3, 16'h1234, 0);
    wr(4'h5, 16'hBEEF, 0);
    idle(0, 4'h3, 4'h0);
    #1 chk("bp_full_ready", 32'(in_ready), 32'h0);
    idle(1, 4'h5, 4'h0);
    idle(1, 4'h5, 4'h0);
    idle(1, 4'h0, 4'h0);

    // Forwarding: youngest of two writes to r7.
    wr(4'h7, 16'h0001, 0);
    wr(4'h7, 16'h0002, 0);
    idle(0, 4'h7, 4'h0);
    idle(0, 4'h6, 4'h0);
    idle(1, 4'h7, 4'h0);
    idle(1, 4'h7, 4'h0);
    idle(1, 4'h7, 4'h0);

    // Simultaneous push/pop at count=1, pointers wrap several times.
    wr(4'h1, 16'h0101, 0);
    for (int k = 2; k <= 8; k++) wr(4'(k), 16'(k * 16'h0101), 1);
    idle(1, 4'h8, 4'h0);
    idle(1, 4'h0, 4'h0);

    // Reset mid-drain discards pending writes.
    wr(4'h9, 16'h9999, 0);
    wr(4'hA, 16'hAAAA, 0);
    step(0, 0, 16'h0, 4'h0, 0, 4'h0, 0, 0, 4'h9, 4'h0);
    idle(1, 4'h9, 4'h0);
    chk("after_rst_rf_we", 32'(rf_we), 32'h0);
    idle(1, 4'hA, 4'h0);

    // Randomized traffic with occasional reset.
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0, 16'($urandom),
           4'($urandom), $urandom_range(0, 3) != 0, 4'($urandom_range(0, 3)),
           $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0,
           4'($urandom_range(0, 3)), 4'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
